// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and the per-cycle action decode for the EX/MEM pipeline register.
// Imported by the interface, the register slice and the top.
package ex_mem_reg_pkg;

   localparam logic RstEnable    = 1'b1;
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = ~WriteEnable;
   localparam logic Stop         = 1'b1;
   localparam logic NoStop       = ~Stop;

   localparam int RegBus       = 32;
   localparam int RegAddrBus   = 5;
   localparam int DoubleRegBus = 64;
   localparam int AluOpBus     = 8;

   localparam logic [RegBus-1:0]   ZeroWord   = '0;
   localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'h00;

   // What the stage register does on the coming edge, highest priority first.
   typedef enum logic [2:0] {
      ST_RESET,
      ST_FLUSH,
      ST_BUBBLE,
      ST_HOLD,
      ST_ADVANCE
   } ctl_e;

   // EX running with MEM stalled cannot happen legally; it falls through to advance.
   function automatic ctl_e decode_action(input logic rst, input logic flush,
                                          input logic ex_stop, input logic mem_stop);
      if (rst == RstEnable)    return ST_RESET;
      if (flush)               return ST_FLUSH;
      if (ex_stop == NoStop)   return ST_ADVANCE;
      if (mem_stop == NoStop)  return ST_BUBBLE;
      return ST_HOLD;
   endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// Signal bundle between the EX stage (master) and the EX/MEM register (slave).
// No handshake: every field is sampled on every rising clock edge; stall/flush alone gate the update.
interface ex_mem_reg_if;
   import ex_mem_reg_pkg::*;

   logic [RegAddrBus-1:0]   ex_wd;
   logic                    ex_wreg;
   logic [RegBus-1:0]       ex_wdata;
   logic                    ex_whilo;
   logic [RegBus-1:0]       ex_hi;
   logic [RegBus-1:0]       ex_lo;
   logic [AluOpBus-1:0]     ex_aluop;
   logic [RegBus-1:0]       ex_mem_addr;
   logic [RegBus-1:0]       ex_reg2;
   logic [DoubleRegBus-1:0] hilo_temp_i;
   logic [1:0]              cnt_i;

   logic [RegAddrBus-1:0]   mem_wd;
   logic                    mem_wreg;
   logic [RegBus-1:0]       mem_wdata;
   logic                    mem_whilo;
   logic [RegBus-1:0]       mem_hi;
   logic [RegBus-1:0]       mem_lo;
   logic [AluOpBus-1:0]     mem_aluop;
   logic [RegBus-1:0]       mem_mem_addr;
   logic [RegBus-1:0]       mem_reg2;
   logic [DoubleRegBus-1:0] hilo_temp_o;
   logic [1:0]              cnt_o;

   modport master (
      output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
             ex_aluop, ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
      input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o
   );

   modport slave (
      input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
             ex_aluop, ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
      output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o
   );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register slice: clear to CLR beats hold, hold beats load.
module pipe_reg #(
   parameter int           W   = 32,
   parameter logic [W-1:0] CLR = '0
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         hold,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= CLR;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush, bubble and hold; MADD/MSUB state is fed back to EX.
// Define EX_MEM_MADD_EN to build the hilo_temp/cnt feedback flops; otherwise they read as zero.
module ex_mem_reg
   import ex_mem_reg_pkg::*;
#(
   parameter int STALL_W = 6,
   parameter int EX_IDX  = 3,
   parameter int MEM_IDX = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   ex_mem_reg_if.slave        bus
);

   localparam int GPR_W  = RegAddrBus + 1 + RegBus;
   localparam int HILO_W = 1 + 2 * RegBus;
   localparam int MEM_W  = AluOpBus + 2 * RegBus;

   // A zeroed stage is a NOP that never writes the GPR file or HI/LO.
   localparam logic [GPR_W-1:0]  GPR_CLR  = {{RegAddrBus{1'b0}}, WriteDisable, ZeroWord};
   localparam logic [HILO_W-1:0] HILO_CLR = {WriteDisable, ZeroWord, ZeroWord};
   localparam logic [MEM_W-1:0]  MEM_CLR  = {EXE_NOP_OP, ZeroWord, ZeroWord};

   ctl_e action;
   logic stage_clear;
   logic stage_hold;
   logic unused_stall;

   always_comb begin
      action      = decode_action(rst, flush, stall[EX_IDX] == Stop, stall[MEM_IDX] == Stop);
      stage_clear = (action == ST_RESET) || (action == ST_FLUSH) || (action == ST_BUBBLE);
      stage_hold  = (action == ST_HOLD);
   end

   assign unused_stall = ^stall;

   logic [GPR_W-1:0]  gpr_q;
   logic [HILO_W-1:0] hilo_q;
   logic [MEM_W-1:0]  mem_q;

   pipe_reg #(.W(GPR_W), .CLR(GPR_CLR)) u_gpr (
      .clk   (clk),
      .clear (stage_clear),
      .hold  (stage_hold),
      .d     ({bus.ex_wd, bus.ex_wreg, bus.ex_wdata}),
      .q     (gpr_q)
   );

   pipe_reg #(.W(HILO_W), .CLR(HILO_CLR)) u_hilo (
      .clk   (clk),
      .clear (stage_clear),
      .hold  (stage_hold),
      .d     ({bus.ex_whilo, bus.ex_hi, bus.ex_lo}),
      .q     (hilo_q)
   );

   pipe_reg #(.W(MEM_W), .CLR(MEM_CLR)) u_mem (
      .clk   (clk),
      .clear (stage_clear),
      .hold  (stage_hold),
      .d     ({bus.ex_aluop, bus.ex_mem_addr, bus.ex_reg2}),
      .q     (mem_q)
   );

   assign {bus.mem_wd, bus.mem_wreg, bus.mem_wdata}        = gpr_q;
   assign {bus.mem_whilo, bus.mem_hi, bus.mem_lo}          = hilo_q;
   assign {bus.mem_aluop, bus.mem_mem_addr, bus.mem_reg2} = mem_q;

`ifdef EX_MEM_MADD_EN
   // Partial product survives only while EX is stalled; any advance consumes it.
   logic madd_clear;
   logic [DoubleRegBus+1:0] madd_q;

   always_comb begin
      madd_clear = (action == ST_RESET) || (action == ST_FLUSH) || (action == ST_ADVANCE);
   end

   pipe_reg #(.W(DoubleRegBus + 2)) u_madd (
      .clk   (clk),
      .clear (madd_clear),
      .hold  (stage_hold),
      .d     ({bus.hilo_temp_i, bus.cnt_i}),
      .q     (madd_q)
   );

   assign {bus.hilo_temp_o, bus.cnt_o} = madd_q;
`else
   logic unused_madd;

   assign unused_madd     = ^{bus.hilo_temp_i, bus.cnt_i};
   assign bus.hilo_temp_o = {ZeroWord, ZeroWord};
   assign bus.cnt_o       = 2'b00;
`endif

endmodule
